// File: rtl/edge_event_monitor.sv
// Registered rose/fell/stable sampler with a pass/fail scorer and a timestamped error FIFO.
// Define EDGE_MON_SYNC_EN to pass `a` through a 2-flop synchronizer before it is sampled.
module edge_event_monitor #(
  parameter bit CHECK_FELL = 1'b1,
  parameter int CNT_W      = 16,
  parameter int TS_W       = 32,
  parameter int DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  output logic             rose,
  output logic             fell,
  output logic             stable,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [TS_W-1:0]  err_time,
  output logic             err_level,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0] ts;
  logic            s;
  logic            prev;

`ifdef EDGE_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], a};
  end

  assign s = sync_q[1];
`else
  assign s = a;
`endif

  logic is_rise, is_fall, sample_ok, sample_bad;

  always_comb begin
    is_rise    = s & ~prev;
    is_fall    = ~s & prev;
    sample_ok  = en & (CHECK_FELL ? is_fall : is_rise);
    sample_bad = en & ~(CHECK_FELL ? is_fall : is_rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= 1'b0;
      rose   <= 1'b0;
      fell   <= 1'b0;
      stable <= 1'b0;
    end else if (en) begin
      prev   <= s;
      rose   <= is_rise;
      fell   <= is_fall;
      stable <= (s == prev);
    end else begin
      rose   <= 1'b0;
      fell   <= 1'b0;
      stable <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      if (sample_ok && (pass_count != {CNT_W{1'b1}}))
        pass_count <= pass_count + CNT_W'(1);
      if (sample_bad && (fail_count != {CNT_W{1'b1}}))
        fail_count <= fail_count + CNT_W'(1);
    end
  end

  // Error FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [TS_W:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push, drop;
  logic [TS_W:0] head;

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop   = ~empty & err_ready;
    // A same-cycle pop frees the slot the incoming record needs.
    push  = sample_bad & (~full | pop);
    drop  = sample_bad & full & ~pop;
    head  = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {ts, s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign err_valid = ~empty;
  assign err_time  = empty ? '0 : head[TS_W:1];
  assign err_level = ~empty & head[0];

endmodule

// File: tb/tb_edge_event_monitor.sv
// Scoreboard bench: fall-mode and rise-mode monitors share stimulus; a reference model
// predicts pulses, counters and error records, and a separate monitor pops and compares.
module tb_edge_event_monitor;
  localparam int CNT_W = 5;
  localparam int TS_W  = 8;
  localparam int DEPTH = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, en, a, err_ready;
  logic             rose_v[2], fell_v[2], stable_v[2], err_valid_v[2], err_level_v[2], ovf_v[2];
  logic [CNT_W-1:0] pass_v[2], fail_v[2];
  logic [TS_W-1:0]  err_time_v[2];

  always #5 clk = ~clk;

  edge_event_monitor #(.CHECK_FELL(1'b1), .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) u_fell (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a),
    .rose(rose_v[0]), .fell(fell_v[0]), .stable(stable_v[0]),
    .pass_count(pass_v[0]), .fail_count(fail_v[0]),
    .err_valid(err_valid_v[0]), .err_ready(err_ready),
    .err_time(err_time_v[0]), .err_level(err_level_v[0]), .overflow(ovf_v[0]));

  edge_event_monitor #(.CHECK_FELL(1'b0), .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) u_rise (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a),
    .rose(rose_v[1]), .fell(fell_v[1]), .stable(stable_v[1]),
    .pass_count(pass_v[1]), .fail_count(fail_v[1]),
    .err_valid(err_valid_v[1]), .err_ready(err_ready),
    .err_time(err_time_v[1]), .err_level(err_level_v[1]), .overflow(ovf_v[1]));

  typedef struct packed {
    logic [TS_W-1:0] t;
    logic            lvl;
  } rec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pop[2];
  rec_t q0[$];
  rec_t q1[$];

  int m_ts;
  bit m_prev, m_rose, m_fell, m_stable, m_q1, m_q2;
  int m_pass[2], m_failc[2], m_occ[2];
  bit m_ovf[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_prev = 0; m_rose = 0; m_fell = 0; m_stable = 0; m_q1 = 0; m_q2 = 0;
    for (int i = 0; i < 2; i++) begin
      m_pass[i] = 0; m_failc[i] = 0; m_occ[i] = 0; m_ovf[i] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_edge(input bit e, input bit x, input bit r);
    bit   s, pop, ok;
    rec_t rr;
`ifdef EDGE_MON_SYNC_EN
    s = m_q2; m_q2 = m_q1; m_q1 = x;
`else
    s = x;
`endif
    for (int i = 0; i < 2; i++) begin
      pop = (m_occ[i] > 0) && r;
      if (e) begin
        ok = (i == 0) ? (!s && m_prev) : (s && !m_prev);
        if (ok) begin
          if (m_pass[i] < CMAX) m_pass[i]++;
        end else begin
          if (m_failc[i] < CMAX) m_failc[i]++;
          if (m_occ[i] - int'(pop) < DEPTH) begin
            rr.t = TS_W'(m_ts);
            rr.lvl = s;
            if (i == 0) q0.push_back(rr);
            else        q1.push_back(rr);
            m_occ[i]++;
          end else begin
            m_ovf[i] = 1;
          end
        end
      end
      if (pop) m_occ[i]--;
    end
    m_rose   = e && s && !m_prev;
    m_fell   = e && !s && m_prev;
    m_stable = e && (s == m_prev);
    if (e) m_prev = s;
    m_ts = (m_ts + 1) % (1 << TS_W);
  endtask

  task automatic check_outs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rose[%0d]", i),      32'(rose_v[i]),      32'(m_rose));
      check($sformatf("fell[%0d]", i),      32'(fell_v[i]),      32'(m_fell));
      check($sformatf("stable[%0d]", i),    32'(stable_v[i]),    32'(m_stable));
      check($sformatf("pass_count[%0d]", i), 32'(pass_v[i]),     32'(m_pass[i]));
      check($sformatf("fail_count[%0d]", i), 32'(fail_v[i]),     32'(m_failc[i]));
      check($sformatf("err_valid[%0d]", i), 32'(err_valid_v[i]), 32'(m_occ[i] > 0));
      check($sformatf("overflow[%0d]", i),  32'(ovf_v[i]),       32'(m_ovf[i]));
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit e, input bit x, input bit r);
    en = e; a = x; err_ready = r;
    @(posedge clk);
    if (rst_n) model_edge(e, x, r);
    #1 check_outs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst err_valid[%0d]", i),  32'(err_valid_v[i]), 32'd0);
      check($sformatf("rst err_time[%0d]", i),   32'(err_time_v[i]),  32'd0);
      check($sformatf("rst pass_count[%0d]", i), 32'(pass_v[i]),      32'd0);
      check($sformatf("rst fail_count[%0d]", i), 32'(fail_v[i]),      32'd0);
      check($sformatf("rst overflow[%0d]", i),   32'(ovf_v[i]),       32'd0);
    end
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every handshake the DUTs present.
  initial begin
    rec_t rr;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        for (int i = 0; i < 2; i++) begin
          if (err_valid_v[i] && err_ready) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_record[%0d]: got time %0d level %0d expected none",
                       i, err_time_v[i], err_level_v[i]);
            end else begin
              rr = (i == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("err_time[%0d]", i),  32'(err_time_v[i]),  32'(rr.t));
              check($sformatf("err_level[%0d]", i), 32'(err_level_v[i]), 32'(rr.lvl));
              n_pop[i]++;
            end
          end
        end
      end
    end
  end

  bit seq [10] = '{0, 1, 1, 1, 1, 1, 1, 0, 1, 1};
  int np;

  initial begin
    n_pop[0] = 0; n_pop[1] = 0;
    rst_n = 1'b0; en = 1'b0; a = 1'b0; err_ready = 1'b0;
    model_reset();
    #1 check_outs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("init err_time[%0d]", i),  32'(err_time_v[i]),  32'd0);
      check($sformatf("init err_level[%0d]", i), 32'(err_level_v[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Reset release, a held low
    cycle(0, 0, 0);
    cycle(1, 0, 0);
`ifndef EDGE_MON_SYNC_EN
    check("first err_time", 32'(err_time_v[0]), 32'd1);
    check("first err_level", 32'(err_level_v[0]), 32'd0);
    check("first stable", 32'(stable_v[0]), 32'd1);
`endif
    repeat (3) cycle(1, 0, 0);

    // Directed fall sequence with consumer ready
    do_reset();
    cycle(0, 0, 0);
    np = n_pop[0];
    for (int k = 0; k < 10; k++) cycle(1, seq[k], 1);
`ifndef EDGE_MON_SYNC_EN
    check("seq pass_count", 32'(pass_v[0]), 32'd1);
    check("seq fail_count", 32'(fail_v[0]), 32'd9);
`endif
    repeat (4) cycle(0, 0, 1);

    // Same sequence, consumer stalled: overflow
    do_reset();
    cycle(0, 0, 0);
    for (int k = 0; k < 10; k++) cycle(1, seq[k], 0);
`ifndef EDGE_MON_SYNC_EN
    check("ovf overflow", 32'(ovf_v[0]), 32'd1);
    check("ovf fail_count", 32'(fail_v[0]), 32'd9);
`endif
    np = n_pop[0];
    repeat (8) cycle(0, 0, 1);
    check("ovf drained", 32'(n_pop[0] - np), 32'd4);

    // Full FIFO with concurrent pop
    do_reset();
    repeat (4) cycle(1, 1, 0);
    cycle(1, 1, 1);
    check("full+pop overflow", 32'(ovf_v[0]), 32'd0);
    np = n_pop[0];
    repeat (6) cycle(0, 0, 1);
    check("full+pop drained", 32'(n_pop[0] - np), 32'd4);

    // Rise mode with enable gating
    do_reset();
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    cycle(1, 1, 0);
`ifndef EDGE_MON_SYNC_EN
    check("rise pass_count", 32'(pass_v[1]), 32'd1);
    check("rise fail_count", 32'(fail_v[1]), 32'd2);
`endif
    repeat (4) cycle(0, 0, 1);

    // Mid-run reset with queued records
    do_reset();
    repeat (3) cycle(1, 1, 0);
    do_reset();
    cycle(0, 0, 0);

    // Randomized runs long enough to saturate counters and wrap the timestamp
    repeat (2) begin
      repeat (320) cycle($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (6) cycle(0, 0, 1);
      do_reset();
      cycle(0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
